// File: rtl/vga_sync_receiver.sv
// Receiving end of a VGA timing interface: measures line/frame length, locks onto stable
// timing and regenerates per-pixel X/Y coordinates of the active area.
`timescale 1ns/1ps
module vga_sync_receiver #(
    parameter int unsigned CW          = 11,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned H_TIMEOUT   = 2047
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          pixel_clk,
    input  logic          hs,
    input  logic          vs,
    input  logic          blank,
    input  logic          err_clr,
    output logic          locked,
    output logic          pix_valid,
    output logic [CW-1:0] RxX,
    output logic [CW-1:0] RxY,
    output logic          frame_start,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic          timing_err
);

    localparam int unsigned MW          = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] TIMEOUT_PRE = CW'(H_TIMEOUT - 1);
    localparam logic [MW-1:0] LOCK_N    = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t        state;
    logic          pixel_clk_q, hs_q, vs_q, blank_q;
    logic [CW-1:0] line_cnt, lines, h_ref;
    logic [MW-1:0] match_cnt;
    logic          have_ref, first_line, frame_bad, y_first;

    logic          tick, hs_fall, vs_fall, blank_rise, timeout;
    logic [CW-1:0] lines_now, h_ref_now;
    logic          frame_bad_now, reload;
    logic [MW-1:0] match_next;

    // Tick/edge detection and the view of this tick's measurements including its own hs fall
    always_comb begin
        tick          = pixel_clk & ~pixel_clk_q;
        hs_fall       = tick & hs_q & ~hs;
        vs_fall       = tick & vs_q & ~vs;
        blank_rise    = tick & ~blank_q & blank;
        lines_now     = (hs_fall && lines != CNT_MAX) ? lines + CW'(1) : lines;
        h_ref_now     = (hs_fall && first_line) ? line_cnt : h_ref;
        frame_bad_now = frame_bad | (hs_fall & ~first_line & (line_cnt != h_ref));
        reload        = frame_bad_now | ~have_ref
                      | (h_ref_now != h_total) | (lines_now != v_total);
        match_next    = reload ? MW'(1) : match_cnt + MW'(1);
        timeout       = tick & ~hs_fall & (line_cnt == TIMEOUT_PRE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= SEARCH;
            pixel_clk_q <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            blank_q     <= 1'b0;
            line_cnt    <= '0;
            lines       <= '0;
            h_ref       <= '0;
            match_cnt   <= '0;
            have_ref    <= 1'b0;
            first_line  <= 1'b0;
            frame_bad   <= 1'b0;
            y_first     <= 1'b0;
            locked      <= 1'b0;
            pix_valid   <= 1'b0;
            RxX         <= '0;
            RxY         <= '0;
            frame_start <= 1'b0;
            h_total     <= '0;
            v_total     <= '0;
            timing_err  <= 1'b0;
        end else begin
            pixel_clk_q <= pixel_clk;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (err_clr)
                timing_err <= 1'b0;

            if (tick) begin
                hs_q      <= hs;
                vs_q      <= vs;
                blank_q   <= blank;
                pix_valid <= locked & blank;

                if (hs_fall)
                    line_cnt <= CW'(1);
                else if (line_cnt != CNT_MAX)
                    line_cnt <= line_cnt + CW'(1);
                lines <= vs_fall ? '0 : lines_now;

                if (blank_rise)
                    RxX <= '0;
                else if (blank)
                    RxX <= RxX + CW'(1);

                // First visible line after a vs fall is row 0
                if (blank_rise) begin
                    RxY     <= y_first ? '0 : RxY + CW'(1);
                    y_first <= 1'b0;
                end
                if (vs_fall)
                    y_first <= 1'b1;

                case (state)
                    SEARCH: begin
                        if (vs_fall) begin
                            state      <= MEASURE;
                            match_cnt  <= '0;
                            have_ref   <= 1'b0;
                            first_line <= 1'b1;
                            frame_bad  <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (hs_fall) begin
                            h_ref      <= h_ref_now;
                            frame_bad  <= frame_bad_now;
                            first_line <= 1'b0;
                        end
                        if (vs_fall) begin
                            first_line <= 1'b1;
                            frame_bad  <= 1'b0;
                            match_cnt  <= match_next;
                            if (reload) begin
                                h_total  <= h_ref_now;
                                v_total  <= lines_now;
                                have_ref <= 1'b1;
                            end
                            if (match_next >= LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if ((hs_fall && line_cnt != h_total) ||
                            (vs_fall && lines_now != v_total)) begin
                            state      <= SEARCH;
                            locked     <= 1'b0;
                            timing_err <= 1'b1;
                        end else if (vs_fall) begin
                            frame_start <= 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase

                // Timeout overrides anything decided above; measurements are held
                if (timeout) begin
                    state      <= SEARCH;
                    locked     <= 1'b0;
                    timing_err <= 1'b1;
                end
            end
        end
    end

endmodule
